// File: rtl/serial_bit_streamer_pkg.sv
// serial_bit_streamer_pkg
//   Shared types and constants for the serial bit streamer and the detector-side
//   bench that consumes its output.
//   - state_e              : streamer FSM states
//   - BIT_ORDER_*          : values for the MSB_FIRST parameter
//   - SD_IDLE_BIT_DEFAULT  : level held on the serial line when nothing is shifting
package serial_bit_streamer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  // The detector side idles its x input at this level too.
  localparam bit SD_IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/serial_bit_streamer_if.sv
// serial_bit_streamer_if
//   Word-input valid/ready handshake of the serial bit streamer.
//   in_data  : word to serialize (DATA_W bits), producer -> streamer
//   in_valid : in_data is valid, producer -> streamer
//   in_ready : streamer can take a word this cycle, streamer -> producer
//   modport master : producer side
//   modport slave  : streamer side
interface serial_bit_streamer_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/serial_bit_streamer_piso_shift_reg.sv
// piso_shift_reg
//   Parallel-load, serial-out shift register with compile-time direction select.
//   Shifting always fills with 0. Load has priority over shift.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, clears the register
//   load      : capture load_data at the next edge
//   shift     : shift one position towards the output end at the next edge
//   load_data : parallel word (WIDTH bits)
//   head_next : bit that will sit at the output end after the next edge, so the
//               caller can register the serial output without a cycle of delay
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             head_next
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = load_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
      end
    end
  end

  assign head_next = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/serial_bit_streamer.sv
// serial_bit_streamer
//   Parallel-to-serial front end for the sequence detector. Accepts DATA_W-bit
//   words on a valid/ready handshake and emits them one bit per clock on sd_x.
//   A word accepted on the last-bit cycle of the previous word continues the
//   stream with no gap, so patterns that straddle word boundaries stay intact.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   in_if        : word handshake (slave side): in_data, in_valid, in_ready
//   sd_x         : registered serial bit to the detector; IDLE_BIT when idle
//   sd_bit_valid : registered, sd_x carries a data bit this cycle
//   busy         : FSM is in ST_SHIFT
//   underrun     : sticky, set when a word ends with no follow-on word
//   clr_underrun : synchronous clear of underrun (a same-cycle set wins)
//   words_sent   : accepted-word count, wraps modulo 2^CNT_W
//   The interface instance must carry the same DATA_W as this module.
module serial_bit_streamer
  import serial_bit_streamer_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = BIT_ORDER_MSB_FIRST,
  parameter bit          IDLE_BIT  = SD_IDLE_BIT_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_bit_streamer_if.slave in_if,
  output logic                 sd_x,
  output logic                 sd_bit_valid,
  output logic                 busy,
  output logic                 underrun,
  input  logic                 clr_underrun,
  output logic [CNT_W-1:0]     words_sent
);

  localparam int unsigned         BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_IDX = BIT_CNT_W'(DATA_W - 1);

  state_e               state;
  logic [BIT_CNT_W-1:0] bit_cnt;

  logic last_bit;
  logic accept;
  logic stay_shift;
  logic stream_end;
  logic head_next;

  // bit_cnt reaches 0 on the final bit of the word being shown.
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == '0);

  // Ready depends on state only, never on in_valid.
  assign in_if.in_ready = (state == ST_IDLE) || last_bit;
  assign accept         = in_if.in_valid && in_if.in_ready;

  // The cycle after this edge still shows a data bit.
  assign stay_shift = accept || ((state == ST_SHIFT) && !last_bit);

  // Last bit shown and nothing queued behind it.
  assign stream_end = last_bit && !accept;

  assign busy = (state == ST_SHIFT);

  piso_shift_reg #(
    .WIDTH     (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (busy),
    .load_data (in_if.in_data),
    .head_next (head_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      sd_x         <= IDLE_BIT;
      sd_bit_valid <= 1'b0;
      underrun     <= 1'b0;
      words_sent   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_SHIFT;
            bit_cnt <= LAST_IDX;
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            // Reload on the last bit: no bubble between words.
            bit_cnt <= LAST_IDX;
          end else if (last_bit) begin
            state <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Outputs registered from the shift register's next head so the first
      // bit appears the cycle right after the accepting edge.
      sd_bit_valid <= stay_shift;
      sd_x         <= stay_shift ? head_next : IDLE_BIT;

      if (stream_end) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end

      if (accept) begin
        words_sent <= words_sent + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_streamer.sv
// tb_serial_bit_streamer
//   Two streamers driven by the same stimulus: dut_a (MSB first, idle 0, 4-bit
//   counter) and dut_b (LSB first, idle 1, 16-bit counter). A bit-queue model
//   predicts every output each cycle; directed sequences pin literal values.
module tb_serial_bit_streamer;
  import serial_bit_streamer_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          clr_underrun = 1'b0;

  int total = 0;
  int bad   = 0;

  serial_bit_streamer_if #(.DATA_W(DW)) bus_a ();
  serial_bit_streamer_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.in_data  = in_data;
  assign bus_a.in_valid = in_valid;
  assign bus_b.in_data  = in_data;
  assign bus_b.in_valid = in_valid;

  logic        sd_x_a, sdv_a, busy_a, und_a;
  logic [3:0]  ws_a;
  logic        sd_x_b, sdv_b, busy_b, und_b;
  logic [15:0] ws_b;

  serial_bit_streamer #(
    .DATA_W    (DW),
    .MSB_FIRST (BIT_ORDER_MSB_FIRST),
    .IDLE_BIT  (1'b0),
    .CNT_W     (4)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus_a),
    .sd_x         (sd_x_a),
    .sd_bit_valid (sdv_a),
    .busy         (busy_a),
    .underrun     (und_a),
    .clr_underrun (clr_underrun),
    .words_sent   (ws_a)
  );

  serial_bit_streamer #(
    .DATA_W    (DW),
    .MSB_FIRST (BIT_ORDER_LSB_FIRST),
    .IDLE_BIT  (1'b1),
    .CNT_W     (16)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus_b),
    .sd_x         (sd_x_b),
    .sd_bit_valid (sdv_b),
    .busy         (busy_b),
    .underrun     (und_b),
    .clr_underrun (clr_underrun),
    .words_sent   (ws_b)
  );

  always #5 clk = ~clk;

  logic        act_x[2], act_v[2], act_rdy[2], act_busy[2], act_und[2];
  logic [31:0] act_ws[2];
  assign act_x[0]    = sd_x_a;
  assign act_x[1]    = sd_x_b;
  assign act_v[0]    = sdv_a;
  assign act_v[1]    = sdv_b;
  assign act_rdy[0]  = bus_a.in_ready;
  assign act_rdy[1]  = bus_b.in_ready;
  assign act_busy[0] = busy_a;
  assign act_busy[1] = busy_b;
  assign act_und[0]  = und_a;
  assign act_und[1]  = und_b;
  assign act_ws[0]   = 32'(ws_a);
  assign act_ws[1]   = 32'(ws_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- model: the upcoming serial bits, head = bit on sd_x -----
  bit          pend[2][16];
  int          npend[2];
  bit          m_und[2];
  int unsigned m_words[2];
  bit          m_acc, m_was;

  function automatic bit idle_of(input int d);
    return (d == 1);
  endfunction

  function automatic int unsigned mask_of(input int d);
    return (d == 0) ? 32'h0000_000F : 32'h0000_FFFF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        npend[d]   = 0;
        m_und[d]   = 1'b0;
        m_words[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_acc = in_valid && (npend[d] <= 1);
        m_was = (npend[d] > 0);
        if (m_was) begin
          for (int k = 0; k < 15; k++) pend[d][k] = pend[d][k+1];
          npend[d]--;
        end
        if (m_acc) begin
          for (int k = 0; k < DW; k++) begin
            pend[d][npend[d]+k] = (d == 0) ? in_data[DW-1-k] : in_data[k];
          end
          npend[d] += DW;
          m_words[d]++;
        end
        if (m_was && npend[d] == 0) m_und[d] = 1'b1;
        else if (clr_underrun) m_und[d] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("sd_x[%0d]", d), 32'(act_x[d]),
              32'((npend[d] > 0) ? pend[d][0] : idle_of(d)));
        check($sformatf("sd_bit_valid[%0d]", d), 32'(act_v[d]), 32'(npend[d] > 0));
        check($sformatf("in_ready[%0d]", d), 32'(act_rdy[d]), 32'(npend[d] <= 1));
        check($sformatf("busy[%0d]", d), 32'(act_busy[d]), 32'(npend[d] > 0));
        check($sformatf("underrun[%0d]", d), 32'(act_und[d]), 32'(m_und[d]));
        check($sformatf("words_sent[%0d]", d), act_ws[d], m_words[d] & mask_of(d));
      end
    end
  end

  // ---------------- log of valid serial bits, oldest in the high bits ------
  logic [31:0] log_a = '0, log_b = '0;
  int          nlog_a = 0, nlog_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (sdv_a) begin
        log_a = {log_a[30:0], sd_x_a};
        nlog_a++;
      end
      if (sdv_b) begin
        log_b = {log_b[30:0], sd_x_b};
        nlog_b++;
      end
    end
  end

  task automatic clear_logs();
    log_a = '0; log_b = '0; nlog_a = 0; nlog_b = 0;
  endtask

  // Called at a negedge; returns at the negedge of the word's first-bit cycle.
  task automatic push(input logic [DW-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!bus_a.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_seen", 32'(n < 40), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_a && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(n < 60), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // reset state
    check("rst_sd_x_a", 32'(sd_x_a), 32'd0);
    check("rst_sd_x_b", 32'(sd_x_b), 32'd1);
    check("rst_valid_a", 32'(sdv_a), 32'd0);
    check("rst_ready_a", 32'(bus_a.in_ready), 32'd1);
    check("rst_words_a", 32'(ws_a), 32'd0);
    @(negedge clk);

    // single word 0xB0
    clear_logs();
    push(8'hB0);
    wait_idle();
    check("single_bits_a", log_a, 32'h0000_00B0);
    check("single_nbits_a", 32'(nlog_a), 32'd8);
    check("single_bits_b", log_b, 32'h0000_000D);
    check("single_idle_x_a", 32'(sd_x_a), 32'd0);
    check("single_idle_x_b", 32'(sd_x_b), 32'd1);
    check("single_idle_valid", 32'(sdv_a), 32'd0);
    check("single_underrun", 32'(und_a), 32'd1);
    check("single_words", 32'(ws_a), 32'd1);

    // underrun clear, then set-over-clear priority on a 0x0D word
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("clr_underrun", 32'(und_a), 32'd0);
    clear_logs();
    push(8'h0D);
    repeat (7) @(negedge clk);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("prio_set_wins_a", 32'(und_a), 32'd1);
    check("prio_set_wins_b", 32'(und_b), 32'd1);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("prio_later_clear", 32'(und_a), 32'd0);
    check("lsb_first_0d", log_b, 32'h0000_00B0);
    check("msb_first_0d", log_a, 32'h0000_000D);

    // back-to-back 0x0B, 0xB0
    clear_logs();
    push(8'h0B);
    push(8'hB0);
    wait_idle();
    check("b2b_bits_a", log_a, 32'h0000_0BB0);
    check("b2b_nbits_a", 32'(nlog_a), 32'd16);
    check("b2b_bits_b", log_b, 32'h0000_D00D);
    check("b2b_words", 32'(ws_a), 32'd4);
    check("b2b_underrun", 32'(und_a), 32'd1);

    // reset during the 4th bit of 0xFF
    push(8'hFF);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_x_a", 32'(sd_x_a), 32'd0);
    check("midrst_x_b", 32'(sd_x_b), 32'd1);
    check("midrst_valid_a", 32'(sdv_a), 32'd0);
    check("midrst_valid_b", 32'(sdv_b), 32'd0);
    check("midrst_words", 32'(ws_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    push(8'h80);
    wait_idle();
    check("post_rst_bits_a", log_a, 32'h0000_0080);
    check("post_rst_nbits_a", 32'(nlog_a), 32'd8);
    check("post_rst_bits_b", log_b, 32'h0000_0001);

    // counter wrap on the 4-bit counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) push(8'(i * 37 + 5));
    wait_idle();
    check("wrap_words_a", 32'(ws_a), 32'd1);
    check("wrap_words_b", 32'(ws_b), 32'd17);
    push(8'h55);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    check("busy_pulse_words_a", 32'(ws_a), 32'd2);
    check("busy_pulse_words_b", 32'(ws_b), 32'd18);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = 8'($urandom);
      clr_underrun = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    in_valid     = 1'b0;
    clr_underrun = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
